// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold limit and one-hot grant
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // A limit of 0 means "hold forever"; the compare value is then unused.
  localparam bit         LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  logic       pick_found;
  logic [2:0] pick_idx;
  logic       release_done;
  logic       release_to;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    for (int k = 0; k < 8; k++) begin
      if (!pick_found && req[ptr_q + 3'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr_q + 3'(k);
      end
    end
  end

  // Release conditions for the current owner; done beats the hold limit.
  always_comb begin
    release_done = done | ~req[idx_q];
    release_to   = LIMIT_EN && (hold_cnt_q == HOLD_LAST) && !release_done;
  end

  // Next-state logic: arbitrate in IDLE, hold or release in GRANT.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          idx_d      = pick_idx;
          grant_d    = 8'b1 << pick_idx;
          hold_cnt_d = 8'd0;
        end
      end
      GRANT: begin
        if (release_done || release_to) begin
          state_d    = IDLE;
          grant_d    = 8'h00;
          ptr_d      = idx_q + 3'd1;
          hold_cnt_d = 8'd0;
          timeout_d  = release_to;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
      end
    endcase
  end

  // State register with synchronous reset overriding any grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 8'h00;
      idx_q      <= 3'd0;
      ptr_q      <= 3'd0;
      hold_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = |grant_q;
  assign timeout     = timeout_q;

endmodule
